reset_sequencer: RTL

- Staged reset release controller downstream of the fabric reset synchronizer.
- Takes the synchronized FABRIC_RESET_N and PLL_LOCK and releases NUM_STAGES domain resets in a fixed order with a programmable gap between them: interconnect first, then peripherals, then the processor core.
- Re-asserts all stage resets on PLL lock loss.
- Serves a four-phase soft-reset handshake from the debug/processor subsystem.

---
 rtl/reset_sequencer_if.sv | 31 +++
 rtl/reset_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer_if.sv
// Handshake and status bundle between the reset sequencer and its consumers.
// The master side drives lock status and the soft-reset request; the slave
// side (the sequencer) returns acknowledge, stage resets and status flags.
interface reset_sequencer_if #(
    parameter int NUM_STAGES = 3
) ();
    logic                  pll_lock;
    logic                  soft_rst_req;
    logic                  soft_rst_ack;
    logic [NUM_STAGES-1:0] stage_reset_n;
    logic                  seq_done;
    logic                  lock_lost;

    modport master (
        output pll_lock,
        output soft_rst_req,
        input  soft_rst_ack,
        input  stage_reset_n,
        input  seq_done,
        input  lock_lost
    );

    modport slave (
        input  pll_lock,
        input  soft_rst_req,
        output soft_rst_ack,
        output stage_reset_n,
        output seq_done,
        output lock_lost
    );
endinterface

// File: rtl/reset_sequencer.sv
// Staged reset release: after PLL lock, domain resets are released one at a
// time in index order with a fixed gap. Lock loss pulls every stage back into
// reset. A four-phase soft-reset handshake holds all stages in reset for a
// fixed time before acknowledging.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// HOLD     | all stages in reset, waiting for PLL lock
// COUNT    | releasing stages one per STAGE_DELAY cycles
// RUN      | all stages released, sequencing done
// ASSERT   | soft reset in progress, stages held for SOFT_HOLD cycles
// WAIT_REL | soft reset acknowledged, waiting for the request to drop
module reset_sequencer #(
    parameter int NUM_STAGES  = 3,
    parameter int STAGE_DELAY = 16,
    parameter int SOFT_HOLD   = 8
) (
    input  logic             clk,
    input  logic             fabric_reset_n,
    reset_sequencer_if.slave seq_if
);

    localparam int MAX_CNT = (STAGE_DELAY > SOFT_HOLD) ? STAGE_DELAY : SOFT_HOLD;
    localparam int CNT_W   = $clog2(MAX_CNT) + 1;
    localparam int IDX_W   = $clog2(NUM_STAGES + 1);

    typedef enum logic [2:0] {
        HOLD     = 3'd0,
        COUNT    = 3'd1,
        RUN      = 3'd2,
        ASSERT   = 3'd3,
        WAIT_REL = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_STAGES-1:0] stage_q, stage_d;
    logic                  done_q, done_d;
    logic                  ack_q, ack_d;
    logic                  lost_q, lost_d;

    logic [NUM_STAGES-1:0] stage_bit;
    logic                  lock_drop;
    logic                  stage_tc;
    logic                  hold_tc;
    logic                  last_stage;

    assign lock_drop  = !seq_if.pll_lock && (state_q != HOLD);
    assign stage_tc   = (cnt_q == CNT_W'(STAGE_DELAY - 1));
    assign hold_tc    = (cnt_q == CNT_W'(SOFT_HOLD - 1));
    assign last_stage = (idx_q == IDX_W'(NUM_STAGES - 1));

    // One-hot select of the stage due for release next.
    always_comb begin
        stage_bit = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                stage_bit[i] = 1'b1;
            end
        end
    end

    // State, counters and registered outputs; fabric reset wins over everything.
    always_ff @(posedge clk) begin
        if (!fabric_reset_n) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            stage_q <= '0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stage_q <= stage_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
            lost_q  <= lost_d;
        end
    end

    // Next-state decision; lock loss takes priority over the soft request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HOLD: begin
                if (seq_if.pll_lock) state_d = COUNT;
            end
            COUNT: begin
                if (!seq_if.pll_lock)           state_d = HOLD;
                else if (stage_tc && last_stage) state_d = RUN;
            end
            RUN: begin
                if (!seq_if.pll_lock)         state_d = HOLD;
                else if (seq_if.soft_rst_req) state_d = ASSERT;
            end
            ASSERT: begin
                if (!seq_if.pll_lock) state_d = HOLD;
                else if (hold_tc)     state_d = WAIT_REL;
            end
            WAIT_REL: begin
                if (!seq_if.pll_lock)          state_d = HOLD;
                else if (!seq_if.soft_rst_req) state_d = HOLD;
            end
            default: state_d = HOLD;
        endcase
    end

    // Next values of counter, stage index and outputs; the counter is cleared
    // on every terminal count and on every state change.
    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        stage_d = stage_q;
        done_d  = done_q;
        ack_d   = ack_q;
        lost_d  = lost_q;
        if (lock_drop) begin
            cnt_d   = '0;
            idx_d   = '0;
            stage_d = '0;
            done_d  = 1'b0;
            ack_d   = 1'b0;
            lost_d  = 1'b1;
        end else begin
            case (state_q)
                HOLD: begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    stage_d = '0;
                    done_d  = 1'b0;
                    ack_d   = 1'b0;
                end
                COUNT: begin
                    if (stage_tc) begin
                        cnt_d   = '0;
                        idx_d   = idx_q + IDX_W'(1);
                        stage_d = stage_q | stage_bit;
                        if (last_stage) done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (seq_if.soft_rst_req) begin
                        cnt_d   = '0;
                        stage_d = '0;
                        done_d  = 1'b0;
                    end
                end
                ASSERT: begin
                    if (hold_tc) begin
                        cnt_d = '0;
                        ack_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                WAIT_REL: begin
                    if (!seq_if.soft_rst_req) begin
                        cnt_d = '0;
                        ack_d = 1'b0;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    stage_d = '0;
                    done_d  = 1'b0;
                    ack_d   = 1'b0;
                end
            endcase
        end
    end

    assign seq_if.stage_reset_n = stage_q;
    assign seq_if.seq_done      = done_q;
    assign seq_if.soft_rst_ack  = ack_q;
    assign seq_if.lock_lost     = lost_q;

endmodule
